// File: rtl/code_change_register_pkg.sv
// code_change_register_pkg: state encoding, default code/permutation and width helper
package code_change_register_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY1 = 2'd1, ENTRY2 = 2'd2, COMMIT = 2'd3} state_t;
  localparam logic [15:0] DEF_CODE = 16'h9070;
  localparam logic [7:0] DEF_PERM = 8'b10_01_11_00;
  function automatic int code_w(int n, int w);
    return n * w;
  endfunction
endpackage

// File: rtl/code_change_register_if.sv
// code_change_register_if: lock-side control, digit entry and status signals of the code register
interface code_change_register_if
  import code_change_register_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int CODE_W = code_w(4, 4)
);
  logic unlocked;
  logic change_req;
  logic abort;
  logic digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic digit_ready;
  logic busy;
  logic commit_done;
  logic mismatch;
  logic aborted;
  logic [CODE_W-1:0] code_out;
  modport master (
    output unlocked, change_req, abort, digit_valid, digit,
    input digit_ready, busy, commit_done, mismatch, aborted, code_out
  );
  modport slave (
    input unlocked, change_req, abort, digit_valid, digit,
    output digit_ready, busy, commit_done, mismatch, aborted, code_out
  );
endinterface

// File: rtl/code_change_register_scrambler.sv
// code_scrambler: combinational digit permutation, slot k takes the source digit named by PERM field k
module code_scrambler #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter logic [NUM_DIGITS*$clog2(NUM_DIGITS)-1:0] PERM = 8'b10_01_11_00
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] code,
  output logic [NUM_DIGITS*DIGIT_W-1:0] scrambled
);
  localparam int SW = $clog2(NUM_DIGITS);
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_slot
    localparam int SRC = int'(PERM[k*SW +: SW]);
    assign scrambled[k*DIGIT_W +: DIGIT_W] = code[SRC*DIGIT_W +: DIGIT_W];
  end
endmodule

// File: rtl/code_change_register.sv
// code_change_register: stored passcode with double-entry digit-serial change and scrambled output.
// Optional entry inactivity timeout enabled by CODE_ENTRY_TIMEOUT_EN.
module code_change_register
  import code_change_register_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter int RADIX = 10,
  parameter logic [code_w(NUM_DIGITS, DIGIT_W)-1:0] DEFAULT_CODE = DEF_CODE,
  parameter logic [NUM_DIGITS*$clog2(NUM_DIGITS)-1:0] PERM = DEF_PERM,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic rst_n,
  code_change_register_if.slave bus
);
  localparam int CW = code_w(NUM_DIGITS, DIGIT_W);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0] LAST = SW'(NUM_DIGITS - 1);
  localparam logic [DIGIT_W:0] RAD = (DIGIT_W + 1)'(RADIX);
  state_t state, next;
  logic [CW-1:0] stored, buf_a, buf_b;
  logic [SW-1:0] cnt, slot;
  logic entry, timeout, cancel, accept, done, match;
  assign entry = state == ENTRY1 || state == ENTRY2;
  assign cancel = entry && (bus.abort || !bus.unlocked || timeout);
  assign accept = entry && !cancel && bus.digit_valid && ({1'b0, bus.digit} < RAD);
  assign done = accept && cnt == LAST;
  assign match = buf_a == buf_b;
  assign slot = LAST - cnt;
  always_comb begin
    next = state;
    bus.digit_ready = entry;
    bus.busy = state != IDLE;
    bus.commit_done = state == COMMIT && match;
    bus.mismatch = state == COMMIT && !match;
    bus.aborted = cancel;
    case (state)
      IDLE:    next = (bus.change_req && bus.unlocked) ? ENTRY1 : IDLE;
      ENTRY1:  next = cancel ? IDLE : done ? ENTRY2 : ENTRY1;
      ENTRY2:  next = cancel ? IDLE : done ? COMMIT : ENTRY2;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // first accepted digit lands in the most significant slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stored <= DEFAULT_CODE;
      cnt <= '0;
      buf_a <= '0;
      buf_b <= '0;
    end else begin
      if (state == COMMIT && match) stored <= buf_a;
      if (accept && state == ENTRY1) buf_a[slot*DIGIT_W +: DIGIT_W] <= bus.digit;
      if (accept && state == ENTRY2) buf_b[slot*DIGIT_W +: DIGIT_W] <= bus.digit;
      cnt <= (state != next) ? '0 : accept ? cnt + 1'b1 : cnt;
      if (next == IDLE) begin
        buf_a <= '0;
        buf_b <= '0;
      end
    end
`ifdef CODE_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idle_cnt <= '0;
    else idle_cnt <= (!entry || accept || state != next) ? '0 : idle_cnt + 1'b1;
  assign timeout = entry && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  code_scrambler #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIGIT_W(DIGIT_W),
    .PERM(PERM)
  ) u_scrambler (
    .code(stored),
    .scrambled(bus.code_out)
  );
endmodule

// File: tb/tb_code_change_register.sv
// tb_code_change_register: random and directed stimulus checked every cycle against a digit-level model
module tb_code_change_register;
  localparam int N = 4;
  localparam int W = 4;
  localparam int TO = 20;
  localparam int PERM_I = 'h9C;
  localparam int DEF_I = 'h9070;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int mode = 0, na = 0, nb = 0, a = 0, b = 0, m_code = DEF_I, idle = 0;
  always #5 clk = ~clk;
  code_change_register_if #(.DIGIT_W(W), .CODE_W(N * W)) bus ();
  code_change_register #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // output slot k, counted from the most significant slot, holds digit PERM field k
  function automatic int scr(int v);
    int r = 0;
    for (int k = 0; k < N; k++) begin
      int src = (PERM_I >> (2 * (N - 1 - k))) & 3;
      r = r * 16 + ((v >> (4 * src)) & 15);
    end
    return r;
  endfunction
  always @(negedge clk) begin
    bit entry, to_e, cancel, acc;
    int nmode, d;
    if (!rst_n) begin
      mode = 0; na = 0; nb = 0; a = 0; b = 0; m_code = DEF_I; idle = 0;
    end
    d = int'(bus.digit);
    entry = mode == 1 || mode == 2;
    to_e = 1'b0;
`ifdef CODE_ENTRY_TIMEOUT_EN
    to_e = entry && idle == TO - 1;
`endif
    cancel = entry && (bus.abort || !bus.unlocked || to_e);
    acc = entry && !cancel && bus.digit_valid && d < 10;
    chk("digit_ready", 32'(bus.digit_ready), 32'(entry));
    chk("busy", 32'(bus.busy), 32'(mode != 0));
    chk("commit_done", 32'(bus.commit_done), 32'(mode == 3 && a == b));
    chk("mismatch", 32'(bus.mismatch), 32'(mode == 3 && a != b));
    chk("aborted", 32'(bus.aborted), 32'(cancel));
    chk("code_out", 32'(bus.code_out), 32'(scr(m_code)));
    if (rst_n) begin
      nmode = mode;
      if (cancel) nmode = 0;
      else if (mode == 0) begin
        if (bus.change_req && bus.unlocked) nmode = 1;
      end else if (mode == 1) begin
        if (acc) begin
          a = a * 16 + d; na++;
          if (na == N) nmode = 2;
        end
      end else if (mode == 2) begin
        if (acc) begin
          b = b * 16 + d; nb++;
          if (nb == N) nmode = 3;
        end
      end else begin
        if (a == b) m_code = a;
        nmode = 0;
      end
      idle = (nmode != mode || acc || !entry) ? 0 : idle + 1;
      if (nmode == 0) begin a = 0; b = 0; na = 0; nb = 0; end
      mode = nmode;
    end
  end
  task automatic set_in(bit r, bit u, bit ab, bit v, logic [3:0] d);
    bus.change_req = r; bus.unlocked = u; bus.abort = ab; bus.digit_valid = v; bus.digit = d;
  endtask
  task automatic cyc(bit r, bit u, bit ab, bit v, logic [3:0] d);
    set_in(r, u, ab, v, d);
    @(posedge clk);
    #1;
  endtask
  task automatic idle_c(); cyc(0, 1, 0, 0, 4'd0); endtask
  task automatic dig(logic [3:0] d); cyc(0, 1, 0, 1, d); endtask
  task automatic start(); cyc(1, 1, 0, 0, 4'd0); endtask
  task automatic enter(logic [3:0] d3, logic [3:0] d2, logic [3:0] d1, logic [3:0] d0);
    dig(d3); dig(d2); dig(d1); dig(d0);
  endtask
  initial begin
    logic [3:0] rd;
    set_in(0, 0, 0, 0, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("reset code_out", 32'(bus.code_out), 32'h0790);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset pulses", 32'({bus.commit_done, bus.mismatch, bus.aborted, bus.digit_ready}), 32'd0);
    @(posedge clk); #1;
    start(); enter(1, 2, 3, 4); enter(1, 2, 3, 5);
    chk("mismatch pulse", 32'(bus.mismatch), 32'd1);
    idle_c();
    chk("code after mismatch", 32'(bus.code_out), 32'h0790);
    start(); enter(1, 2, 3, 4); enter(1, 2, 3, 4);
    chk("commit pulse", 32'(bus.commit_done), 32'd1);
    idle_c();
    chk("code after commit", 32'(bus.code_out), 32'h2314);
    cyc(1, 0, 0, 0, 4'd0);
    chk("locked req busy", 32'(bus.busy), 32'd0);
    start(); dig(5); dig(6);
    set_in(0, 1, 1, 1, 4'd7);
    #2 chk("abort pulse", 32'(bus.aborted), 32'd1);
    @(posedge clk); #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort code", 32'(bus.code_out), 32'h2314);
    start(); dig(9); dig(4'hC); dig(0); dig(7); dig(0); enter(9, 0, 7, 0);
    chk("range commit", 32'(bus.commit_done), 32'd1);
    idle_c();
    chk("range code", 32'(bus.code_out), 32'h0790);
`ifdef CODE_ENTRY_TIMEOUT_EN
    start(); dig(1);
    repeat (TO - 1) idle_c();
    set_in(0, 1, 0, 0, 4'd0);
    #2 chk("timeout pulse", 32'(bus.aborted), 32'd1);
    @(posedge clk); #1;
    chk("timeout busy", 32'(bus.busy), 32'd0);
`else
    start(); dig(1);
    repeat (TO + 5) idle_c();
    chk("no timeout busy", 32'(bus.busy), 32'd1);
    cyc(0, 1, 1, 0, 4'd0);
`endif
    start(); enter(1, 2, 3, 4); enter(1, 2, 3, 4); idle_c();
    chk("second commit code", 32'(bus.code_out), 32'h2314);
    start(); enter(1, 2, 3, 4); dig(1); dig(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset code", 32'(bus.code_out), 32'h0790);
    chk("async reset busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rd = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 2)) : 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 19) != 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) < 7, rd);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/code_change_register.md
Name: code_change_register

Overview:
- Parametrised successor to the fixed 16-bit stored-code register in the safe lock controller.
- Holds the N-digit passcode in a register that is initialised from a parameter at reset.
- Supports a digit-serial code-change sequence: the new code is entered twice and committed only if both entries match, and only while the lock is unlocked.
- Drives the stored code to the comparator as a digit-permuted (scrambled) word.

Parameters:
- NUM_DIGITS, 4: digits in the code (2..8).
- DIGIT_W, 4: bits per digit.
- RADIX, 10: valid digit values are 0..RADIX-1.
- DEFAULT_CODE, 16'h9070: code loaded at reset, NUM_DIGITS*DIGIT_W bits, digit 0 in the LSBs.
- PERM, 8'b10_01_11_00: output slot k (MSB slot first) takes source digit PERM field k; each field is clog2(NUM_DIGITS) bits. Default gives {D2,D1,D3,D0}.
- TIMEOUT_CYCLES, 1000: idle cycles allowed during entry (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- unlocked  in  1  lock FSM is in the unlocked state.
- change_req  in  1  single-cycle request to start a code change.
- abort  in  1  cancel the change in progress.
- digit_valid  in  1  digit is presented.
- digit  in  DIGIT_W  digit value.
- digit_ready  out  1  block accepts a digit this cycle.
- busy  out  1  change sequence in progress.
- commit_done  out  1  one-cycle pulse: new code stored.
- mismatch  out  1  one-cycle pulse: the two entries differed, code unchanged.
- aborted  out  1  one-cycle pulse: sequence cancelled.
- code_out  out  NUM_DIGITS*DIGIT_W  scrambled stored code.

Behaviour:
- Reset (async, rst_n=0):
  - stored code = DEFAULT_CODE.
  - state = IDLE, digit counter = 0, both entry buffers = 0.
  - All pulse outputs = 0; busy = 0; digit_ready = 0.
  - code_out = PERM(DEFAULT_CODE); with the defaults this is 16'h0790.
- code_out is a purely combinational permutation of the stored register, so it has no latency relative to the register.
- States: IDLE, ENTRY1, ENTRY2, COMMIT.
- IDLE:
  - change_req=1 and unlocked=1 -> ENTRY1, counter cleared.
  - change_req while locked is ignored; no pulse is generated.
- Digit acceptance:
  - digit_ready=1 in ENTRY1 and ENTRY2 only.
  - A digit is accepted when digit_valid && digit_ready && digit < RADIX.
  - An accepted digit is written into the buffer slot given by the counter, first digit to the most significant slot; the counter then increments.
  - An out-of-range digit is dropped and not counted.
- ENTRY1: accepting digit NUM_DIGITS-1 -> ENTRY2, counter cleared.
- ENTRY2: fills buffer B the same way; accepting the last digit -> COMMIT.
- COMMIT (one cycle):
  - A==B: stored code <= A and commit_done=1; code_out reflects the new code on the following cycle.
  - Otherwise: mismatch=1 and the stored code is unchanged.
  - Always -> IDLE.
- Cancellation:
  - abort=1, or unlocked=0, in ENTRY1 or ENTRY2 -> IDLE with aborted=1 and stored code unchanged.
  - Cancellation has priority over a digit presented in the same cycle.
- abort in IDLE or COMMIT is ignored; COMMIT always completes.
- change_req outside IDLE is ignored.
- busy=1 in every state except IDLE.
- Buffers A and B are cleared on entry to IDLE, so the plaintext code does not persist.
- Reset asserted mid-sequence returns to the reset state: the stored code reverts to DEFAULT_CODE and no pulses are generated.

Optional Feature:
- Macro: CODE_ENTRY_TIMEOUT_EN.
- Defined:
  - A counter runs in ENTRY1 and ENTRY2, clears on each accepted digit and on state entry.
  - Reaching TIMEOUT_CYCLES without an accepted digit -> IDLE with aborted=1, same effect as abort.
- Undefined: no counter is built; entry waits indefinitely.

Decomposition:
- Shared package/header holds:
  - state encoding constants (IDLE=0, ENTRY1=1, ENTRY2=2, COMMIT=3);
  - default parameter values (DEFAULT_CODE, PERM);
  - a code-width function NUM_DIGITS*DIGIT_W.
- Sub-module code_scrambler: combinational digit permutation, parameterised by NUM_DIGITS, DIGIT_W and PERM. It is reused by the comparator path.

Test Plan:
- Reset release, no stimulus -> code_out=16'h0790, busy=0, all pulses 0.
- unlocked=1, change_req, digits 1,2,3,4 then 1,2,3,4 -> commit_done pulses in the COMMIT cycle; next cycle code_out = {2,3,1,4} = 16'h2314.
- unlocked=1, change_req, digits 1,2,3,4 then 1,2,3,5 -> mismatch=1, code_out stays 16'h0790.
- unlocked=0, change_req -> busy stays 0. Then unlocked=1, change_req, 2 digits, then abort asserted together with a valid digit -> aborted=1, code unchanged, digit not counted.
- During ENTRY1, digit=4'hC with digit_valid -> counter unchanged; then digits 9,0,7,0 x2 -> commit, code_out=16'h0790.
- With CODE_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=20: change_req, one digit, then 20 idle cycles -> aborted pulse, IDLE, code unchanged. Repeat with rst_n asserted mid-ENTRY2 -> code_out=16'h0790 immediately.
